// File: rtl/output_port_ctrl.sv
// Router output port: wormhole lock on the granted input, credit-based flow control to the link.
// Optional send counter (stat_flits) is built when OUTPUT_PORT_STATS_EN is defined.
module output_port_ctrl #(
    parameter int FLIT_W  = 64,
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        requests,
    input  logic [1:0]        granted,
    input  logic [4*FLIT_W-1:0] flit_in,
    input  logic [3:0]        flit_tail,
    input  logic              credit_in,
    output logic [3:0]        pop,
    output logic [3:0]        blockedRequests,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_tail,
    output logic [CW-1:0]     credits,
    output logic              busy
`ifdef OUTPUT_PORT_STATS_EN
    ,
    output logic [31:0]       stat_flits
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

    state_t            state_reg, state_next;
    logic [1:0]        owner_reg, owner_next;
    logic [CW-1:0]     credits_reg, credits_next;
    logic              out_valid_reg;
    logic [FLIT_W-1:0] out_flit_reg;
    logic              out_tail_reg;

    logic [FLIT_W-1:0] slot [4];
    logic [1:0]        sel;
    logic              send;

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign slot[gi] = flit_in[gi*FLIT_W +: FLIT_W];
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        credits_next    = credits_reg;
        pop             = '0;
        blockedRequests = '0;

        // While locked the arbiter's choice is ignored: only the owner may advance.
        sel  = (state_reg == LOCKED) ? owner_reg : granted;
        send = reset && requests[sel] && (credits_reg != '0);

        if (send) begin
            pop[sel] = 1'b1;
            if (state_reg == IDLE && !flit_tail[sel]) begin
                state_next = LOCKED;
                owner_next = sel;
            end else if (state_reg == LOCKED && flit_tail[sel]) begin
                state_next = IDLE;
            end
        end

        if (send && !credit_in)
            credits_next = credits_reg - CW'(1);
        else if (!send && credit_in && credits_reg != CREDITS_MAX)
            credits_next = credits_reg + CW'(1);

        if (credits_reg == '0)
            blockedRequests = 4'hF;
        else if (state_reg == LOCKED)
            blockedRequests = ~(4'b0001 << owner_reg);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_reg     <= 2'd0;
            credits_reg   <= CREDITS_MAX;
            out_valid_reg <= 1'b0;
            out_flit_reg  <= '0;
            out_tail_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            credits_reg   <= credits_next;
            out_valid_reg <= send;
            if (send) begin
                out_flit_reg <= slot[sel];
                out_tail_reg <= flit_tail[sel];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_flit  = out_flit_reg;
    assign out_tail  = out_tail_reg;
    assign credits   = credits_reg;
    assign busy      = (state_reg == LOCKED);

`ifdef OUTPUT_PORT_STATS_EN
    logic [31:0] stat_reg;

    always_ff @(posedge clk) begin
        if (!reset)
            stat_reg <= '0;
        else if (send)
            stat_reg <= stat_reg + 32'd1;
    end

    assign stat_flits = stat_reg;
`endif

endmodule

// File: tb/tb_output_port_ctrl.sv
// Bench for output_port_ctrl: vector table for per-cycle control outputs, scoreboard for the link side.
module tb_output_port_ctrl;

    localparam int FLIT_W  = 64;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic [3:0]          requests;
    logic [1:0]          granted;
    logic [4*FLIT_W-1:0] flit_in;
    logic [3:0]          flit_tail;
    logic                credit_in;
    logic [3:0]          pop;
    logic [3:0]          blockedRequests;
    logic                out_valid;
    logic [FLIT_W-1:0]   out_flit;
    logic                out_tail;
    logic [CW-1:0]       credits;
    logic                busy;

    output_port_ctrl #(.FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
        .clk             (clk),
        .reset           (reset),
        .requests        (requests),
        .granted         (granted),
        .flit_in         (flit_in),
        .flit_tail       (flit_tail),
        .credit_in       (credit_in),
        .pop             (pop),
        .blockedRequests (blockedRequests),
        .out_valid       (out_valid),
        .out_flit        (out_flit),
        .out_tail        (out_tail),
        .credits         (credits),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [1:0] gnt;
        logic [3:0] tail;
        logic       cin;
        logic [3:0] epop;
        logic [3:0] eblk;
        logic       ebusy;
        logic [2:0] ecred;
    } vec_t;

    typedef struct {
        logic [FLIT_W-1:0] flit;
        logic              tail;
    } exp_t;

    exp_t              sb[$];
    logic [FLIT_W-1:0] last_flit;
    logic              last_tail;
    int                tests = 0;
    int                fails = 0;
    vec_t              tbl [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then check the link after the edge.
    task automatic step(input int idx, input vec_t v);
        exp_t e;
        int   s;
        @(negedge clk);
        requests  = v.req;
        granted   = v.gnt;
        flit_tail = v.tail;
        credit_in = v.cin;
        for (int i = 0; i < 4; i++)
            flit_in[i*FLIT_W +: FLIT_W] = {$urandom, $urandom};
        #1;
        check($sformatf("pop[%0d]", idx), 64'(pop), 64'(v.epop));
        check($sformatf("blocked[%0d]", idx), 64'(blockedRequests), 64'(v.eblk));
        check($sformatf("busy[%0d]", idx), 64'(busy), 64'(v.ebusy));
        check($sformatf("credits[%0d]", idx), 64'(credits), 64'(v.ecred));
        if (v.epop != 4'b0) begin
            s = 0;
            for (int i = 0; i < 4; i++)
                if (v.epop[i]) s = i;
            e.flit = flit_in[s*FLIT_W +: FLIT_W];
            e.tail = v.tail[s];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("out_valid[%0d]", idx), 64'(out_valid), 64'd1);
            check($sformatf("out_flit[%0d]", idx), out_flit, e.flit);
            check($sformatf("out_tail[%0d]", idx), 64'(out_tail), 64'(e.tail));
            last_flit = e.flit;
            last_tail = e.tail;
        end else begin
            check($sformatf("out_valid[%0d]", idx), 64'(out_valid), 64'd0);
            check($sformatf("hold_flit[%0d]", idx), out_flit, last_flit);
            check($sformatf("hold_tail[%0d]", idx), 64'(out_tail), 64'(last_tail));
        end
        $display("[TB] vec %0d req=%b gnt=%0d cin=%b pop=%b blk=%b cred=%0d", idx, v.req, v.gnt, v.cin,
                 pop, blockedRequests, credits);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset    = 1'b0;
        requests = 4'hF;
        granted  = 2'd0;
        #1;
        check({tag, "_pop"}, 64'(pop), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_flit"}, out_flit, 64'd0);
        check({tag, "_out_tail"}, 64'(out_tail), 64'd0);
        check({tag, "_credits"}, 64'(credits), 64'(CREDITS));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        sb.delete();
        last_flit = '0;
        last_tail = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        requests = 4'h0;
        $display("[TB] reset %s done", tag);
    endtask

    initial begin
        //                req      gnt   tail     cin   pop      blk    busy  cred
        tbl[0]  = '{4'b0100, 2'd2, 4'b0100, 1'b0, 4'b0100, 4'h0,   1'b0, 3'd4}; // single flit
        tbl[1]  = '{4'b0000, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0,   1'b0, 3'd3};
        tbl[2]  = '{4'b0010, 2'd1, 4'b0000, 1'b0, 4'b0010, 4'h0,   1'b0, 3'd4}; // head, lock input 1
        tbl[3]  = '{4'b1010, 2'd3, 4'b0000, 1'b0, 4'b0010, 4'b1101, 1'b1, 3'd3};
        tbl[4]  = '{4'b1000, 2'd3, 4'b1000, 1'b1, 4'b0000, 4'b1101, 1'b1, 3'd2}; // owner idle
        tbl[5]  = '{4'b1010, 2'd3, 4'b0010, 1'b0, 4'b0010, 4'b1101, 1'b1, 3'd3}; // tail
        tbl[6]  = '{4'b1000, 2'd3, 4'b1000, 1'b1, 4'b1000, 4'h0,   1'b0, 3'd2}; // send+credit
        tbl[7]  = '{4'b0001, 2'd0, 4'b0001, 1'b0, 4'b0001, 4'h0,   1'b0, 3'd2};
        tbl[8]  = '{4'b0001, 2'd0, 4'b0001, 1'b0, 4'b0001, 4'h0,   1'b0, 3'd1};
        tbl[9]  = '{4'b0001, 2'd0, 4'b0001, 1'b0, 4'b0000, 4'hF,   1'b0, 3'd0}; // starved
        tbl[10] = '{4'b0001, 2'd0, 4'b0001, 1'b1, 4'b0000, 4'hF,   1'b0, 3'd0};
        tbl[11] = '{4'b0001, 2'd0, 4'b0001, 1'b0, 4'b0001, 4'h0,   1'b0, 3'd1};
        tbl[12] = '{4'b0000, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'hF,   1'b0, 3'd0};
        tbl[13] = '{4'b0000, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0,   1'b0, 3'd1};
        tbl[14] = '{4'b0000, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0,   1'b0, 3'd2};
        tbl[15] = '{4'b0000, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0,   1'b0, 3'd3};
        tbl[16] = '{4'b0000, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0,   1'b0, 3'd4}; // saturate
        tbl[17] = '{4'b0000, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'h0,   1'b0, 3'd4};

        reset     = 1'b0;
        requests  = 4'h0;
        granted   = 2'd0;
        flit_in   = '0;
        flit_tail = 4'h0;
        credit_in = 1'b0;
        last_flit = '0;
        last_tail = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("init");

        for (int i = 0; i < 18; i++)
            step(i, tbl[i]);

        // Reset in the middle of a packet from input 2.
        step(100, '{4'b0100, 2'd2, 4'b0000, 1'b0, 4'b0100, 4'h0,   1'b0, 3'd4});
        step(101, '{4'b0100, 2'd0, 4'b0000, 1'b0, 4'b0100, 4'b1011, 1'b1, 3'd3});
        do_reset("midpkt");
        // Afterwards the port is IDLE: granted steers again.
        step(102, '{4'b0100, 2'd1, 4'b0100, 1'b0, 4'b0000, 4'h0,   1'b0, 3'd4});
        step(103, '{4'b0100, 2'd2, 4'b0100, 1'b0, 4'b0100, 4'h0,   1'b0, 3'd4});
        step(104, '{4'b0000, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'h0,   1'b0, 3'd3});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_port_ctrl.md
OUTPUT_PORT_CTRL -- requirements
Module: output_port_ctrl

Interface
REQ-001 Parameter FLIT_W, 64, flit payload width in bits.
REQ-002 Parameter CREDITS, 4, downstream buffer depth; credit counter width CW = clog2(CREDITS+1).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, named as the codebase does:
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous reset, active-low.
REQ-006 requests  in  4  bit i: input port i holds a head flit destined for this output.
REQ-007 granted  in  2  arbiter's selected input index.
REQ-008 flit_in  in  4*FLIT_W  slot i at [i*FLIT_W +: FLIT_W], head flit of input i.
REQ-009 flit_tail  in  4  bit i: head flit of input i is a packet tail.
REQ-010 credit_in  in  1  one downstream slot freed this cycle.
REQ-011 pop  out  4  one-hot, combinational dequeue strobe to input i.
REQ-012 blockedRequests  out  4  combinational block mask fed back to the arbiter.
REQ-013 out_valid  out  1  registered flit valid on the link.
REQ-014 out_flit  out  FLIT_W  registered flit payload.
REQ-015 out_tail  out  1  registered tail flag.
REQ-016 credits  out  CW  current credit count.
REQ-017 busy  out  1  high in state LOCKED.

Function
REQ-018 States SHALL be IDLE and LOCKED; a 2-bit register owner holds the locked input.
REQ-019 In IDLE, a send SHALL occur when requests[granted]=1 and credits>0; sel = granted.
REQ-020 In LOCKED, a send SHALL occur when requests[owner]=1 and credits>0; sel = owner; granted is ignored.
REQ-021 On send, pop[sel] SHALL be 1 in the same cycle; otherwise pop=0.
REQ-022 On send, out_flit/out_tail SHALL load flit_in slot sel / flit_tail[sel] at the next edge, with out_valid=1 for exactly that following cycle (latency 1).
REQ-023 With no send, out_valid SHALL be 0 next cycle; out_flit and out_tail SHALL hold.
REQ-024 IDLE->LOCKED on a send with flit_tail[sel]=0, latching owner=sel; a send with tail=1 stays IDLE (single-flit packet).
REQ-025 LOCKED->IDLE on a send with flit_tail[owner]=1.
REQ-026 credits SHALL decrement on send, increment on credit_in, remain unchanged when both occur.
REQ-027 credit_in at credits=CREDITS without a send SHALL be ignored (saturate); send is impossible at credits=0.
REQ-028 blockedRequests SHALL equal 4'hF when credits=0; else 4'h0 in IDLE; else ~onehot(owner) in LOCKED.
REQ-029 No flit from a non-owner input SHALL be popped while LOCKED.

Reset
REQ-030 With reset=0 at a clock edge: state=IDLE, owner=0, credits=CREDITS, out_valid=0, out_flit=0, out_tail=0.
REQ-031 Reset mid-packet SHALL abandon the packet and restore full credits; pop SHALL be 0 while reset=0.

Configuration
REQ-032 Macro OUTPUT_PORT_STATS_EN: when defined, output port stat_flits (32 bits, out) SHALL count sends, wrap at 2^32-1->0, clear on reset.
REQ-033 Without OUTPUT_PORT_STATS_EN, the stat_flits port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 Single-flit: reset, requests=4'b0100, granted=2, flit_tail[2]=1 -> pop=4'b0100 that cycle, next cycle out_valid=1, out_flit=slot2, out_tail=1, credits=3, busy=0.
REQ-035 Wormhole lock: 3-flit packet from input 1 (tail on third), granted switches to 3 mid-packet -> pops only input 1, blockedRequests=4'b1101 while busy, IDLE after tail.
REQ-036 Credit starvation: CREDITS=4, 4 sends with no credit_in -> credits=0, blockedRequests=4'hF, no pop; one credit_in -> next send proceeds.
REQ-037 Simultaneous send and credit_in at credits=2 -> credits stays 2; credit_in at credits=4 -> stays 4.
REQ-038 Reset in LOCKED after 2 of 3 flits -> state IDLE, credits=4, out_valid=0; with OUTPUT_PORT_STATS_EN, stat_flits=0.
